// File: rtl/trace_scheduler_pkg.sv
// Shared types and constants for the column trace scheduler and the tracer side.
package trace_pkg;

    localparam int COL_W    = 10;
    localparam int HEIGHT_W = 8;

    localparam int DEF_NUM_COLS       = 640;
    localparam int DEF_MAX_HEIGHT     = 240;
    localparam int DEF_TIMEOUT_CYCLES = 63;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/trace_scheduler_if.sv
// Tracer request/response and column-buffer write bundle between scheduler and its neighbours.
interface trace_scheduler_if;

    logic                             trc_start;
    logic [trace_pkg::COL_W-1:0]      trc_column;
    logic                             trc_done;
    logic                             trc_side;
    logic [trace_pkg::HEIGHT_W-1:0]   trc_height;

    logic                             buf_we;
    logic                             buf_bank;
    logic [trace_pkg::COL_W-1:0]      buf_addr;
    logic                             buf_side;
    logic [trace_pkg::HEIGHT_W-1:0]   buf_height;

    // Scheduler side: issues trace requests and writes the column buffer.
    modport master (
        output trc_start, trc_column, buf_we, buf_bank, buf_addr, buf_side, buf_height,
        input  trc_done, trc_side, trc_height
    );

    // Tracer/buffer side.
    modport slave (
        input  trc_start, trc_column, buf_we, buf_bank, buf_addr, buf_side, buf_height,
        output trc_done, trc_side, trc_height
    );

endinterface

// File: rtl/trace_scheduler_height_clamp.sv
// Combinational wall-height clamp: zero becomes 1, anything taller than MAX_HEIGHT saturates.
module height_clamp
    import trace_pkg::*;
#(
    parameter int MAX_HEIGHT = DEF_MAX_HEIGHT
) (
    input  logic [HEIGHT_W-1:0] raw_height,
    output logic [HEIGHT_W-1:0] clamped_height
);

    localparam logic [HEIGHT_W-1:0] MAX_H = HEIGHT_W'(MAX_HEIGHT);

    // A zero-height wall would vanish on screen, so it is drawn as one pixel.
    always_comb begin
        clamped_height = raw_height;
        if (raw_height == '0) begin
            clamped_height = HEIGHT_W'(1);
        end else if (raw_height > MAX_H) begin
            clamped_height = MAX_H;
        end
    end

endmodule

// File: rtl/trace_scheduler.sv
// Walks every column of a frame through the tracer and writes the results into the
// back bank of a double-buffered column store, swapping banks once the frame is complete.
module trace_scheduler
    import trace_pkg::*;
#(
    parameter int NUM_COLS       = DEF_NUM_COLS,
    parameter int MAX_HEIGHT     = DEF_MAX_HEIGHT,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              frame_start,
    trace_scheduler_if.master bus,
    output logic              front_bank,
    output logic              frame_ready,
    output logic              overrun
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
    localparam int               TMO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    sched_state_t        state_q;
    sched_state_t        state_d;
    logic [COL_W-1:0]    column_q;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic                side_q;
    logic [HEIGHT_W-1:0] height_q;
    logic [HEIGHT_W-1:0] height_clamped;

    logic start_frame;
    logic issue;
    logic capture;
    logic timed_out;
    logic tmo_step;
    logic write_col;
    logic last_write;

    height_clamp #(
        .MAX_HEIGHT (MAX_HEIGHT)
    ) u_clamp (
        .raw_height     (bus.trc_height),
        .clamped_height (height_clamped)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state strobes; enable low parks the FSM in IDLE with no strobes.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        issue       = 1'b0;
        capture     = 1'b0;
        timed_out   = 1'b0;
        tmo_step    = 1'b0;
        write_col   = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        start_frame = 1'b1;
                        state_d     = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    issue   = 1'b1;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.trc_done) begin
                        capture = 1'b1;
                        state_d = ST_WRITE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        timed_out = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        tmo_step = 1'b1;
                    end
                end
                ST_WRITE: begin
                    write_col = 1'b1;
                    state_d   = (column_q == LAST_COL) ? ST_IDLE : ST_ISSUE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign last_write = write_col && (column_q == LAST_COL);

    // Column walk, timeout count, captured tracer result, bank swap and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            column_q    <= '0;
            tmo_cnt_q   <= '0;
            side_q      <= 1'b0;
            height_q    <= '0;
            front_bank  <= 1'b0;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_ready <= last_write;
            if (last_write) begin
                front_bank <= ~front_bank;
            end
            if (!enable || start_frame || last_write) begin
                column_q <= '0;
            end else if (write_col) begin
                column_q <= column_q + COL_W'(1);
            end
            if (issue) begin
                tmo_cnt_q <= '0;
            end else if (tmo_step) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
            if (capture) begin
                side_q   <= bus.trc_side;
                height_q <= height_clamped;
            end else if (timed_out) begin
                side_q   <= 1'b0;
                height_q <= HEIGHT_W'(1);
            end
            if ((frame_start && (state_q != ST_IDLE)) || timed_out) begin
                overrun <= 1'b1;
            end
        end
    end

    assign bus.trc_start  = issue;
    assign bus.trc_column = column_q;
    assign bus.buf_we     = write_col;
    assign bus.buf_bank   = ~front_bank;
    assign bus.buf_addr   = column_q;
    assign bus.buf_side   = write_col ? side_q : 1'b0;
    assign bus.buf_height = write_col ? height_q : '0;

endmodule

// File: doc/trace_scheduler.md
TRACE_SCHEDULER -- requirements
Module: trace_scheduler

Interface
REQ-001 Parameter NUM_COLS, default 640: columns traced per frame.
REQ-002 Parameter MAX_HEIGHT, default 240: largest legal wall height.
REQ-003 Parameter TIMEOUT_CYCLES, default 63: WAIT cycles before a column is abandoned.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  high = scheduler may run; low = abort and idle.
REQ-007 frame_start  input  1  single-cycle pulse requesting a new frame trace (from VGA vblank).
REQ-008 trc_start  output  1  single-cycle pulse telling the tracer to trace trc_column.
REQ-009 trc_column  output  10  column index for the tracer; held stable from ISSUE through WRITE.
REQ-010 trc_done  input  1  tracer result valid, sampled only in WAIT.
REQ-011 trc_side  input  1  wall side of the result.
REQ-012 trc_height  input  8  raw wall height of the result.
REQ-013 buf_we  output  1  single-cycle write strobe to the column buffer.
REQ-014 buf_bank  output  1  bank being written; always the inverse of front_bank.
REQ-015 buf_addr  output  10  column address, equal to trc_column during WRITE.
REQ-016 buf_side  output  1  side written to the buffer.
REQ-017 buf_height  output  8  clamped height written to the buffer.
REQ-018 front_bank  output  1  bank the display reads from.
REQ-019 frame_ready  output  1  single-cycle pulse on the cycle after the final column's WRITE.
REQ-020 overrun  output  1  sticky flag: frame_start arrived while not IDLE, or a column timed out.

Function
REQ-021 The FSM SHALL have four states: IDLE, ISSUE, WAIT and WRITE.
REQ-022 IDLE: when frame_start and enable are both high, the FSM SHALL load column 0 and go to ISSUE.
REQ-023 ISSUE: the block SHALL assert trc_start for exactly one cycle, clear the timeout counter and go to WAIT.
REQ-024 WAIT: when trc_done is high, the block SHALL capture trc_side/trc_height and go to WRITE.
- The earliest legal trc_done is the cycle after trc_start.
- The minimum cost is therefore 3 cycles per column.
REQ-025 WAIT: when the counter reaches TIMEOUT_CYCLES without trc_done, the block SHALL go to WRITE with side 0 and height 1, and set overrun.
REQ-026 WRITE: the block SHALL assert buf_we for exactly one cycle.
- Address = current column.
- Height clamped: 0 becomes 1; values above MAX_HEIGHT become MAX_HEIGHT; otherwise passed unchanged.
REQ-027 WRITE with column < NUM_COLS-1: the block SHALL increment the column and go to ISSUE.
REQ-028 WRITE with column = NUM_COLS-1: the block SHALL toggle front_bank, pulse frame_ready on the next cycle, and go to IDLE.
REQ-029 frame_start outside IDLE SHALL be ignored for sequencing, set overrun, and leave the current frame running.
REQ-030 trc_done outside WAIT SHALL be ignored.
REQ-031 enable low in any state SHALL, at the next edge, force IDLE and column 0.
- No write, no bank swap and no frame_ready result from the aborted frame.
- trc_start and buf_we are low in that cycle.
REQ-032 frame_start and the final WRITE in the same cycle SHALL set overrun; that frame_start does not start a new frame.
REQ-033 The column counter SHALL never exceed NUM_COLS-1, and SHALL never wrap within a frame.

Reset
REQ-034 While reset_n is low, the block SHALL asynchronously hold these values: state IDLE, column 0, front_bank 0 (so buf_bank 1), and all other outputs 0 (trc_start, trc_column, buf_we, buf_addr, buf_side, buf_height, frame_ready, overrun).
REQ-035 After reset_n rises, the block SHALL do nothing until the first frame_start with enable high.
REQ-036 Reset asserted mid-frame SHALL discard the frame without a bank swap.
REQ-037 overrun SHALL be cleared only by reset.

Structure
REQ-038 A shared package trace_pkg SHALL hold:
- the state enum;
- COL_W=10 and HEIGHT_W=8;
- default values of NUM_COLS, MAX_HEIGHT and TIMEOUT_CYCLES.
REQ-039 The height clamp SHALL be a combinational sub-module named height_clamp, reused by the tracer bench.
REQ-040 All other logic SHALL live in trace_scheduler; no memories inside it.

Verification
REQ-041 Bench with NUM_COLS=4, enable=1, frame_start pulse, tracer answering 1 cycle after each trc_start with heights 10,20,30,40.
- Expect 4 writes to addr 0..3 on bank 1.
- Expect front_bank 0 to 1, then frame_ready one cycle later.
- Expect 12 cycles from first trc_start to final buf_we.
REQ-042 Tracer heights 0, 241, 255, 240.
- Expect buf_height values 1, 240, 240, 240.
REQ-043 Tracer never answers on column 2 (TIMEOUT_CYCLES=5).
- Expect a write of height 1, side 0 after 5 WAIT cycles.
- Expect overrun=1 and the frame to complete.
REQ-044 frame_start re-pulsed during column 1.
- Expect overrun=1 and exactly 4 writes.
- Expect no restart and a single bank swap.
REQ-045 Drop enable during WAIT of column 2, then drop reset_n mid-frame on a rerun.
- Expect IDLE, no further buf_we and front_bank unchanged in both cases.
- Expect all outputs at reset values immediately on reset_n low.
